// File: rtl/strobe_sequencer.sv
// strobe_sequencer: synchronised, edge-detected, divided trigger launching a delay/pulse/holdoff strobe.
// Optional macro STROBE_SEQ_MISS_CNT_EN adds the saturating missed-trigger counter (miss_count).
module strobe_sequencer #(
   parameter int CNT_W  = 32,
   parameter int MISS_W = 16
) (
   input  logic              clk48,
   input  logic              rst_n,
   input  logic              trig_in,
   input  logic              enable,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_addr,
   input  logic [CNT_W-1:0]  cfg_wdata,
   output logic              strobe_out,
   output logic              busy,
   output logic              trig_acc
`ifdef STROBE_SEQ_MISS_CNT_EN
   ,
   output logic [MISS_W-1:0] miss_count
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PULSE, S_HOLD} state_t;

   state_t           state, state_nxt;
   logic             sync_p0, sync_p1, sync_p2;
   logic             qedge;
   logic [CNT_W-1:0] div_reg, delay_reg, width_reg, hold_reg;
   logic [CNT_W-1:0] width_sh, hold_sh;
   logic [CNT_W-1:0] div_cnt, tmr;
   logic [CNT_W-1:0] div_eff, div_wdata;
   logic             accept, div_wr, pulse_on;

   function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   // Trigger path: two synchroniser flops, third flop for rising-edge detect
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
      end else begin
         sync_p0 <= trig_in;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
      end
   end

   assign qedge  = sync_p1 & ~sync_p2;
   assign div_wr = cfg_we && (cfg_addr == 2'd0);

`ifdef STROBE_SEQ_MISS_CNT_EN
   assign div_wdata = {1'b0, cfg_wdata[CNT_W-2:0]};
`else
   assign div_wdata = cfg_wdata;
`endif

   assign div_eff = at_least_one(div_reg);
   assign accept  = (state == S_IDLE) && enable && qedge && (div_cnt >= div_eff - CNT_W'(1));

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         div_reg   <= CNT_W'(1);
         delay_reg <= '0;
         width_reg <= CNT_W'(480);
         hold_reg  <= '0;
      end else if (cfg_we) begin
         case (cfg_addr)
            2'd0:    div_reg   <= div_wdata;
            2'd1:    delay_reg <= cfg_wdata;
            2'd2:    width_reg <= cfg_wdata;
            default: hold_reg  <= cfg_wdata;
         endcase
      end
   end

   // Divider: only edges seen while already idle count towards acceptance
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         trig_acc <= 1'b0;
      end else begin
         trig_acc <= accept;
         if (div_wr || !enable || accept)
            div_cnt <= '0;
         else if ((state == S_IDLE) && qedge)
            div_cnt <= div_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = (delay_reg != '0) ? S_DELAY : S_PULSE;
         S_DELAY: if (tmr == '0) state_nxt = S_PULSE;
         S_PULSE: if (tmr == '0) state_nxt = (hold_sh != '0) ? S_HOLD : S_IDLE;
         S_HOLD:  if (tmr == '0) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pulse_on = 1'b0;
      busy     = 1'b0;
      if (state == S_PULSE) pulse_on = 1'b1;
      if (state != S_IDLE)  busy     = 1'b1;
   end

   // Timing shadows are captured at accept so register writes never disturb a sequence in flight
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         tmr      <= '0;
         width_sh <= CNT_W'(480);
         hold_sh  <= '0;
      end else if (accept) begin
         width_sh <= at_least_one(width_reg);
         hold_sh  <= hold_reg;
         tmr      <= (delay_reg != '0) ? delay_reg - CNT_W'(1)
                                       : at_least_one(width_reg) - CNT_W'(1);
      end else begin
         case (state)
            S_DELAY: tmr <= (tmr == '0) ? width_sh - CNT_W'(1) : tmr - CNT_W'(1);
            S_PULSE: begin
               if (tmr != '0)           tmr <= tmr - CNT_W'(1);
               else if (hold_sh != '0)  tmr <= hold_sh - CNT_W'(1);
               else                     tmr <= '0;
            end
            S_HOLD:  if (tmr != '0) tmr <= tmr - CNT_W'(1);
            default: tmr <= tmr;
         endcase
      end
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) strobe_out <= 1'b0;
      else        strobe_out <= pulse_on;
   end

`ifdef STROBE_SEQ_MISS_CNT_EN
   // Edges consumed while not idle (including the re-entry edge) are dropped and tallied
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n)
         miss_count <= '0;
      else if (div_wr && cfg_wdata[CNT_W-1])
         miss_count <= '0;
      else if (qedge && (state != S_IDLE) && (miss_count != {MISS_W{1'b1}}))
         miss_count <= miss_count + MISS_W'(1);
   end
`endif

endmodule

// File: tb/tb_strobe_sequencer.sv
// Bench for strobe_sequencer: directed and random stimulus against a cycle-indexed behavioural model.
`timescale 1ns/1ps
module tb_strobe_sequencer;
   localparam int CNT_W  = 32;
   localparam int MISS_W = 16;

   logic              clk48 = 1'b0;
   logic              rst_n = 1'b0;
   logic              trig_in = 1'b0;
   logic              enable = 1'b0;
   logic              cfg_we = 1'b0;
   logic [1:0]        cfg_addr = '0;
   logic [CNT_W-1:0]  cfg_wdata = '0;
   logic              strobe_out, busy, trig_acc;
`ifdef STROBE_SEQ_MISS_CNT_EN
   logic [MISS_W-1:0] miss_count;
`endif

   int compared   = 0;
   int mismatched = 0;

   strobe_sequencer #(.CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
      .clk48      (clk48),
      .rst_n      (rst_n),
      .trig_in    (trig_in),
      .enable     (enable),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .strobe_out (strobe_out),
      .busy       (busy),
      .trig_acc   (trig_acc)
`ifdef STROBE_SEQ_MISS_CNT_EN
      ,
      .miss_count (miss_count)
`endif
   );

   always #10 clk48 = ~clk48;

   // Reference model: each accepted trigger at edge a owns the window of edges up to a+D+W+H
   longint cyc, seq_start, seq_end, s_start, s_end;
   longint m_div, m_delay, m_width, m_hold, m_cnt, m_miss, m_w;
   bit     prev_trig, qd0, qd1, m_acc, m_qual, m_idle;

   always @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0; seq_start = 1; seq_end = 0; s_start = 1; s_end = 0;
         m_div = 1; m_delay = 0; m_width = 480; m_hold = 0; m_cnt = 0; m_miss = 0;
         prev_trig = 0; qd0 = 0; qd1 = 0; m_acc = 0;
      end else begin
         cyc++;
         m_qual = qd1;
         qd1 = qd0;
         qd0 = trig_in && !prev_trig;
         prev_trig = trig_in;
         m_idle = (cyc > seq_end);
         m_acc = 0;
         if (m_qual && m_idle && enable) begin
            m_cnt++;
            if (m_cnt >= ((m_div == 0) ? 1 : m_div)) begin
               m_acc = 1;
               m_cnt = 0;
               m_w = (m_width == 0) ? 1 : m_width;
               seq_start = cyc;
               s_start = cyc + 1 + m_delay;
               s_end = cyc + m_delay + m_w;
               seq_end = cyc + m_delay + m_w + m_hold;
            end
         end
         if (m_qual && !m_idle && m_miss < 65535) m_miss++;
         if (!enable) m_cnt = 0;
         if (cfg_we) begin
            case (cfg_addr)
               2'd0: begin
`ifdef STROBE_SEQ_MISS_CNT_EN
                  m_div = cfg_wdata & 32'h7FFF_FFFF;
                  if (cfg_wdata[31]) m_miss = 0;
`else
                  m_div = cfg_wdata;
`endif
                  m_cnt = 0;
               end
               2'd1: m_delay = cfg_wdata;
               2'd2: m_width = cfg_wdata;
               default: m_hold = cfg_wdata;
            endcase
         end
      end
   end

   longint hi_cnt, rises, acc_cnt, first_rise, t0;
   logic   prev_strobe = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk48);
         chk("strobe_out", strobe_out, (cyc >= s_start && cyc <= s_end));
         chk("busy", busy, (cyc >= seq_start && cyc < seq_end));
         chk("trig_acc", trig_acc, m_acc);
`ifdef STROBE_SEQ_MISS_CNT_EN
         chk("miss_count", miss_count, m_miss);
`endif
         if (strobe_out === 1'b1) hi_cnt++;
         if (trig_acc === 1'b1) acc_cnt++;
         if (strobe_out === 1'b1 && prev_strobe === 1'b0) begin
            rises++;
            if (first_rise < 0) first_rise = cyc;
         end
         prev_strobe = strobe_out;
      end
   endtask

   task automatic clear_obs();
      hi_cnt = 0; rises = 0; acc_cnt = 0; first_rise = -1;
   endtask

   task automatic write(input logic [1:0] a, input logic [CNT_W-1:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      step(1);
      cfg_we = 1'b0;
   endtask

   task automatic pulse_trig(input int hi, input int lo);
      trig_in = 1'b1;
      step(hi);
      trig_in = 1'b0;
      step(lo);
   endtask

   initial begin
      clear_obs();
      enable = 1'b1;
      step(4);
      chk("reset_strobe", strobe_out, 0);
      chk("reset_busy", busy, 0);
      chk("reset_trig_acc", trig_acc, 0);
      rst_n = 1'b1;

      // Defaults after reset: one trigger gives a 480-cycle strobe three edges after sampling
      clear_obs(); t0 = cyc;
      pulse_trig(10, 600);
      chk("dflt_width", hi_cnt, 480);
      chk("dflt_rise", first_rise - (t0 + 1), 3);
      chk("dflt_acc", acc_cnt, 1);

      // Divide by three over nine triggers
      write(2'd0, 3);
      clear_obs(); t0 = cyc;
      for (int i = 0; i < 9; i++) pulse_trig(10, 990);
      chk("div3_rises", rises, 3);
      chk("div3_acc", acc_cnt, 3);
      chk("div3_width", hi_cnt, 1440);
      chk("div3_first", first_rise - (t0 + 1), 2003);

      // Delay / width / holdoff with triggers every 20 cycles
`ifdef STROBE_SEQ_MISS_CNT_EN
      write(2'd0, 32'h8000_0001);
`else
      write(2'd0, 1);
`endif
      write(2'd1, 100);
      write(2'd2, 10);
      write(2'd3, 50);
      clear_obs(); t0 = cyc;
      for (int i = 0; i < 8; i++) pulse_trig(5, 15);
      step(200);
      chk("dly_rise", first_rise - (t0 + 1), 103);
      chk("dly_width", hi_cnt, 10);
      chk("dly_acc", acc_cnt, 1);
`ifdef STROBE_SEQ_MISS_CNT_EN
      chk("dly_miss", miss_count, 7);
`endif

      // Width rewritten mid-pulse only affects the next pulse
      write(2'd1, 0);
      write(2'd3, 0);
      write(2'd2, 480);
      clear_obs();
      pulse_trig(10, 100);
      write(2'd2, 5);
      step(500);
      chk("shadow_first", hi_cnt, 480);
      clear_obs();
      pulse_trig(10, 50);
      chk("shadow_next", hi_cnt, 5);

      // DIVISOR=0 and WIDTH=0 both behave as 1
      write(2'd0, 0);
      write(2'd2, 0);
      clear_obs();
      for (int i = 0; i < 4; i++) pulse_trig(3, 7);
      chk("zero_rises", rises, 4);
      chk("zero_width", hi_cnt, 4);
      chk("zero_acc", acc_cnt, 4);

      // enable dropped mid-pulse: pulse completes, later triggers ignored until re-enabled
      write(2'd0, 1);
      write(2'd2, 50);
      clear_obs();
      pulse_trig(3, 20);
      enable = 1'b0;
      step(60);
      chk("en_width", hi_cnt, 50);
      clear_obs();
      for (int i = 0; i < 3; i++) pulse_trig(3, 20);
      chk("en_off_rises", rises, 0);
      enable = 1'b1;
      step(2);
      pulse_trig(3, 60);
      chk("en_on_rises", rises, 1);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) trig_in = ~trig_in;
         if ($urandom_range(0, 199) == 0) enable = ~enable;
         if ($urandom_range(0, 49) == 0) begin
            cfg_we = 1'b1;
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_wdata = (cfg_addr == 2'd0) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 20));
`ifdef STROBE_SEQ_MISS_CNT_EN
            if (cfg_addr == 2'd0 && $urandom_range(0, 3) == 0) cfg_wdata[31] = 1'b1;
`endif
         end else begin
            cfg_we = 1'b0;
         end
         step(1);
      end
      cfg_we = 1'b0; trig_in = 1'b0; enable = 1'b1;
      step(100);

      // Asynchronous reset in the middle of a pulse
      write(2'd0, 1);
      write(2'd1, 0);
      write(2'd3, 0);
      write(2'd2, 480);
      pulse_trig(3, 50);
      chk("pre_rst_strobe", strobe_out, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_strobe_now", strobe_out, 0);
      chk("rst_busy_now", busy, 0);
      step(3);
      rst_n = 1'b1;
      write(2'd1, 0);
      clear_obs();
      pulse_trig(5, 600);
      chk("post_rst_rises", rises, 1);
      chk("post_rst_width", hi_cnt, 480);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
